env_scaler: RTL and testbench
=============================

// Module: env_scaler
// PURPOSE
//   Serial shift-add multiplier that scales one voice's waveform sample by its 8-bit envelope level.
//   Sits directly downstream of the envelope generator and answers its mult_start/mult_ready handshake.
//   It converts the unsigned offset-binary oscillator sample to two's complement and multiplies it by env_i.
//   It keeps the scaled result per voice in voice0_o..voice2_o, which feed the filter/mixer.
// PARAMETERS
//   WAVE_W  12  waveform sample width (offset-binary in, two's-complement out)
//   ENV_W   8   envelope level width; also the number of RUN iterations
// PORTS
//   clk_i        in   1       system clock
//   rst_ni       in   1       asynchronous active-low reset
//   start_i      in   1       start request; single-cycle pulse from the envelope's mult_start
//   voice_idx_i  in   2       voice being processed, 0..2; 3 is invalid
//   wave_i       in   WAVE_W  oscillator sample, offset-binary (0x800 = zero)
//   env_i        in   ENV_W   envelope level, unsigned (0xFF = full scale)
//   busy_o       out  1       high in RUN and DONE
//   ready_o      out  1       one-cycle completion pulse; drives the envelope's mult_ready
//   product_o    out  WAVE_W  signed scaled result of the last operation
//   voice0_o     out  WAVE_W  signed scaled result held for voice 0
//   voice1_o     out  WAVE_W  signed scaled result held for voice 1
//   voice2_o     out  WAVE_W  signed scaled result held for voice 2
// BEHAVIOUR
//   Reset (async, rst_ni=0):
//     - state=IDLE; all outputs, accumulator and counter = 0.
//     - Reset asserted mid-RUN aborts the operation; no voice register is written.
//   FSM states: IDLE, RUN, DONE.
//     - IDLE -> RUN on the edge where start_i=1.
//     - RUN -> DONE on the edge that completes iteration ENV_W-1.
//     - DONE -> IDLE unconditionally.
//   Operand capture (edge where start_i=1 and state=IDLE):
//     - a   = {~wave_i[MSB], wave_i[MSB-1:0]}, sign-extended to WAVE_W+ENV_W bits.
//     - b   = env_i.
//     - acc = 0; cnt = 0; idx = voice_idx_i.
//     - After capture, changes on wave_i, env_i and voice_idx_i have no effect.
//   RUN, one iteration per clock:
//     - If b[0]=1, acc <= acc + a.
//     - Then a <= a<<1, b <= b>>1, cnt <= cnt+1.
//     - ENV_W iterations in total.
//   Result:
//     - res = acc >>> ENV_W (arithmetic shift, floor rounding), truncated to WAVE_W bits.
//     - The acc width WAVE_W+ENV_W is sufficient, so there is no overflow or saturation.
//     - res is registered into product_o on the RUN->DONE edge.
//     - On the same edge, res goes into voice{idx}_o if idx<=2.
//     - idx==3: computation completes and ready_o pulses; no voice register changes.
//   Latency:
//     - start_i high in cycle 0; RUN occupies cycles 1..ENV_W; ready_o=1 in cycle ENV_W+1 only.
//     - product_o and voice outputs are already valid in that ready cycle and hold until overwritten.
//   start_i handling:
//     - Ignored while busy_o=1, including the DONE cycle.
//     - A new start is accepted in the first IDLE cycle after DONE.
//   env_i = 0 or wave_i = 0x800 gives result 0 exactly.
// TESTING
//   1. wave_i=0xFFF, env_i=0xFF, idx=0 -> ready_o in cycle 9; product_o=voice0_o=0x7F7 (2039).
//   2. wave_i=0x000, env_i=0xFF, idx=1 -> voice1_o=0x808 (-2040); voice0_o unchanged.
//   3. wave_i=0xC00, env_i=0x80, idx=2 -> voice2_o=0x200.
//      Then wave_i=0x7FF, env_i=0x01 -> 0xFFF (floor of -1/256).
//   4. Operand stability: start, then toggle wave_i/env_i/voice_idx_i and pulse start_i during RUN and DONE.
//      Required: the result matches the captured operands; exactly one ready_o pulse; no extra operation.
//   5. idx=3, wave_i=0xFFF, env_i=0xFF -> product_o=0x7F7, ready_o pulses once, voice0..2_o unchanged.
//   6. Assert rst_ni=0 at cycle 4 of RUN -> all outputs 0, busy_o=0.
//      After release, a new start completes normally with ready_o in cycle 9.

Source files
------------

// File: rtl/env_scaler_if.sv
// Handshake and result bundle between the envelope generator, env_scaler and the filter/mixer.
interface env_scaler_if #(
   parameter int WAVE_W = 12,
   parameter int ENV_W  = 8
);
   logic              start_i;
   logic [1:0]        voice_idx_i;
   logic [WAVE_W-1:0] wave_i;
   logic [ENV_W-1:0]  env_i;
   logic              busy_o;
   logic              ready_o;
   logic [WAVE_W-1:0] product_o;
   logic [WAVE_W-1:0] voice0_o;
   logic [WAVE_W-1:0] voice1_o;
   logic [WAVE_W-1:0] voice2_o;

   modport master (
      output start_i, voice_idx_i, wave_i, env_i,
      input  busy_o, ready_o, product_o, voice0_o, voice1_o, voice2_o
   );

   modport slave (
      input  start_i, voice_idx_i, wave_i, env_i,
      output busy_o, ready_o, product_o, voice0_o, voice1_o, voice2_o
   );
endinterface

// File: rtl/env_scaler.sv
// Serial shift-add multiplier scaling an offset-binary waveform sample by an unsigned envelope level.
// Keeps the latest signed result per voice for the downstream filter/mixer.
module env_scaler #(
   parameter int WAVE_W = 12,
   parameter int ENV_W  = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   env_scaler_if.slave  bus
);
   localparam int ACC_W = WAVE_W + ENV_W;
   localparam int CNT_W = $clog2(ENV_W) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  a_q, a_d;
   logic [ENV_W-1:0]  b_q, b_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic              ready_q, ready_d;
   logic [WAVE_W-1:0] product_q, product_d;
   logic [WAVE_W-1:0] voice0_q, voice0_d;
   logic [WAVE_W-1:0] voice1_q, voice1_d;
   logic [WAVE_W-1:0] voice2_q, voice2_d;
   logic [ACC_W-1:0]  acc_sum;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         ready_q   <= 1'b0;
         product_q <= '0;
         voice0_q  <= '0;
         voice1_q  <= '0;
         voice2_q  <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         ready_q   <= ready_d;
         product_q <= product_d;
         voice0_q  <= voice0_d;
         voice1_q  <= voice1_d;
         voice2_q  <= voice2_d;
      end
   end

   // The final iteration's partial product must be included in the result written on RUN->DONE.
   assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      ready_d   = 1'b0;
      product_d = product_q;
      voice0_d  = voice0_q;
      voice1_d  = voice1_q;
      voice2_d  = voice2_q;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = RUN;
               a_d     = {{ENV_W{~bus.wave_i[WAVE_W-1]}}, ~bus.wave_i[WAVE_W-1],
                          bus.wave_i[WAVE_W-2:0]};
               b_d     = bus.env_i;
               acc_d   = '0;
               cnt_d   = '0;
               idx_d   = bus.voice_idx_i;
            end
         end
         RUN: begin
            acc_d = acc_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ENV_W - 1)) begin
               state_d   = DONE;
               ready_d   = 1'b1;
               product_d = acc_sum[ACC_W-1:ENV_W];
               case (idx_q)
                  2'd0:    voice0_d = acc_sum[ACC_W-1:ENV_W];
                  2'd1:    voice1_d = acc_sum[ACC_W-1:ENV_W];
                  2'd2:    voice2_d = acc_sum[ACC_W-1:ENV_W];
                  default: ;
               endcase
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy_o    = (state_q != IDLE);
   assign bus.ready_o   = ready_q;
   assign bus.product_o = product_q;
   assign bus.voice0_o  = voice0_q;
   assign bus.voice1_o  = voice1_q;
   assign bus.voice2_o  = voice2_q;
endmodule

// File: tb/tb_env_scaler.sv
// Directed and randomized bench for env_scaler against an arithmetic model of the scaling rule.
module tb_env_scaler;
   localparam int WAVE_W = 12;
   localparam int ENV_W  = 8;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   env_scaler_if #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) bus();

   env_scaler #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [WAVE_W-1:0] exp_product;
   logic [WAVE_W-1:0] exp_voice [3];

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Signed sample value times envelope, divided by 2^ENV_W with floor rounding.
   function automatic logic [WAVE_W-1:0] ref_scale(input logic [WAVE_W-1:0] wave,
                                                   input logic [ENV_W-1:0] env);
      int s, p, r;
      s = int'(wave) - (1 << (WAVE_W - 1));
      p = s * int'(env);
      r = p >>> ENV_W;
      return r[WAVE_W-1:0];
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".product"}, 32'(bus.product_o), 32'(exp_product));
      check({tag, ".voice0"},  32'(bus.voice0_o),  32'(exp_voice[0]));
      check({tag, ".voice1"},  32'(bus.voice1_o),  32'(exp_voice[1]));
      check({tag, ".voice2"},  32'(bus.voice2_o),  32'(exp_voice[2]));
   endtask

   // Starts one operation in the current cycle and checks latency, results and the single ready pulse.
   task automatic run_op(input string tag, input logic [WAVE_W-1:0] wave,
                         input logic [ENV_W-1:0] env, input logic [1:0] idx);
      int cyc;
      bus.wave_i      = wave;
      bus.env_i       = env;
      bus.voice_idx_i = idx;
      bus.start_i     = 1'b1;
      tick();
      bus.start_i = 1'b0;
      cyc = 1;
      check({tag, ".busy_run"}, 32'(bus.busy_o), 32'd1);
      while (bus.ready_o !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, ".ready_cycle"}, 32'(cyc), 32'(ENV_W + 1));
      exp_product = ref_scale(wave, env);
      if (idx <= 2'd2) exp_voice[idx] = exp_product;
      check_outputs(tag);
      tick();
      check({tag, ".ready_drop"}, 32'(bus.ready_o), 32'd0);
      check({tag, ".busy_idle"},  32'(bus.busy_o),  32'd0);
   endtask

   initial begin
      int pulses;
      logic [WAVE_W-1:0] w;
      logic [ENV_W-1:0]  e;

      bus.start_i     = 1'b0;
      bus.voice_idx_i = '0;
      bus.wave_i      = '0;
      bus.env_i       = '0;
      exp_product     = '0;
      for (int i = 0; i < 3; i++) exp_voice[i] = '0;

      tick();
      tick();
      check("reset.busy",  32'(bus.busy_o),  32'd0);
      check("reset.ready", 32'(bus.ready_o), 32'd0);
      check_outputs("reset");
      rst_ni = 1'b1;
      tick();

      run_op("full_pos",  12'hFFF, 8'hFF, 2'd0);
      check("full_pos.value", 32'(bus.voice0_o), 32'h7F7);
      run_op("full_neg",  12'h000, 8'hFF, 2'd1);
      check("full_neg.value", 32'(bus.voice1_o), 32'h808);
      run_op("half",      12'hC00, 8'h80, 2'd2);
      check("half.value", 32'(bus.voice2_o), 32'h200);
      run_op("floor",     12'h7FF, 8'h01, 2'd2);
      check("floor.value", 32'(bus.voice2_o), 32'hFFF);
      run_op("idx3",      12'hFFF, 8'hFF, 2'd3);
      run_op("env_zero",  12'h123, 8'h00, 2'd0);
      run_op("wave_zero", 12'h800, 8'hFF, 2'd1);

      // Operand stability: inputs and start churn while busy must not disturb the captured operation.
      bus.wave_i      = 12'h9A5;
      bus.env_i       = 8'hC3;
      bus.voice_idx_i = 2'd1;
      bus.start_i     = 1'b1;
      exp_product     = ref_scale(12'h9A5, 8'hC3);
      exp_voice[1]    = exp_product;
      tick();
      pulses = 0;
      for (int c = 1; c <= 14; c++) begin
         if (bus.ready_o === 1'b1) pulses++;
         if (c <= ENV_W + 1) begin
            bus.wave_i      = WAVE_W'($urandom);
            bus.env_i       = ENV_W'($urandom);
            bus.voice_idx_i = 2'($urandom);
            bus.start_i     = 1'($urandom_range(0, 1));
         end else begin
            bus.start_i = 1'b0;
         end
         tick();
      end
      check("stable.pulses", 32'(pulses), 32'd1);
      check("stable.busy",   32'(bus.busy_o), 32'd0);
      check_outputs("stable");

      for (int n = 0; n < 24; n++) begin
         w = WAVE_W'($urandom);
         e = ENV_W'($urandom);
         if (n % 6 == 5) e = '0;
         if (n % 7 == 3) w = 12'h800;
         run_op($sformatf("rand%0d", n), w, e, 2'($urandom_range(0, 3)));
      end

      // Reset in the middle of RUN aborts the operation and clears every output.
      bus.wave_i      = 12'hFFF;
      bus.env_i       = 8'hFF;
      bus.voice_idx_i = 2'd0;
      bus.start_i     = 1'b1;
      tick();
      bus.start_i = 1'b0;
      for (int c = 1; c < 4; c++) tick();
      #2;
      rst_ni = 1'b0;
      #1;
      exp_product = '0;
      for (int i = 0; i < 3; i++) exp_voice[i] = '0;
      check("midreset.busy",  32'(bus.busy_o),  32'd0);
      check("midreset.ready", 32'(bus.ready_o), 32'd0);
      check_outputs("midreset");
      tick();
      tick();
      #2;
      rst_ni = 1'b1;
      tick();
      check_outputs("after_reset");
      run_op("post_reset", 12'h000, 8'h7F, 2'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
